// File: rtl/alarm_pkg.sv
// Shared encodings and reset defaults for the alarm interval timer.
package alarm_pkg;

  // Interval selector encoding, shared by interval_sel and time_param_sel.
  typedef enum logic [1:0] {
    ARM_DELAY       = 2'd0,
    DRIVER_DELAY    = 2'd1,
    PASSENGER_DELAY = 2'd2,
    ALARM_ON        = 2'd3
  } interval_e;

  // Interval register defaults, in seconds.
  localparam int unsigned ARM_DELAY_DEF       = 6;
  localparam int unsigned DRIVER_DELAY_DEF    = 8;
  localparam int unsigned PASSENGER_DELAY_DEF = 15;
  localparam int unsigned ALARM_ON_DEF        = 10;

  // Countdown state.
  typedef enum logic {
    IDLE     = 1'b0,
    COUNTING = 1'b1
  } state_e;

endpackage

// File: rtl/one_hz_div.sv
// Free-running one-second tick divider with synchronous clear.
module one_hz_div #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned DIV_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_HZ - 1);

  logic [DIV_W-1:0] div_q;

  // Count 0..CLK_HZ-1 and wrap; clear restarts the second from zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (clear || (div_q == DIV_MAX)) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign tick = (div_q == DIV_MAX);

endmodule

// File: rtl/alarm_timer.sv
// Programmable seconds countdown timer for the arming / door / siren intervals.
module alarm_timer
  import alarm_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned CNT_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [1:0]       interval_sel,
  input  logic             prog_sync,
  input  logic [1:0]       time_param_sel,
  input  logic [CNT_W-1:0] time_value,
  output logic             expired,
  output logic [CNT_W-1:0] remaining,
  output logic             one_hz_enable
);

  logic [CNT_W-1:0] interval_q [4];
  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic             tick;
  logic             load_c;

  // A load happens on the first edge that sees run while idle.
  assign load_c = run && (state_q == IDLE);

  one_hz_div #(
    .CLK_HZ(CLK_HZ)
  ) u_one_hz_div (
    .clock(clock),
    .reset(reset),
    .clear(load_c),
    .tick (tick)
  );

  // User-programmable interval registers; a write never touches a running count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      interval_q[ARM_DELAY]       <= CNT_W'(ARM_DELAY_DEF);
      interval_q[DRIVER_DELAY]    <= CNT_W'(DRIVER_DELAY_DEF);
      interval_q[PASSENGER_DELAY] <= CNT_W'(PASSENGER_DELAY_DEF);
      interval_q[ALARM_ON]        <= CNT_W'(ALARM_ON_DEF);
    end else if (prog_sync) begin
      interval_q[time_param_sel] <= time_value;
    end
  end

  // Countdown FSM: load on run, decrement per tick, saturate at zero, drop on !run.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else if (!run) begin
      state_q <= IDLE;
      count_q <= '0;
    end else if (state_q == IDLE) begin
      state_q <= COUNTING;
      count_q <= interval_q[interval_sel];
    end else if (tick && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign expired       = (state_q == COUNTING) && (count_q == '0);
  assign remaining     = count_q;
  assign one_hz_enable = tick;

endmodule

// File: tb/tb_alarm_timer.sv
// Self-checking bench for alarm_timer with a cycle-arithmetic reference model.
module tb_alarm_timer;

  localparam int unsigned CLK_HZ = 4;
  localparam int unsigned CNT_W  = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             run = 1'b0;
  logic [1:0]       interval_sel = '0;
  logic             prog_sync = 1'b0;
  logic [1:0]       time_param_sel = '0;
  logic [CNT_W-1:0] time_value = '0;
  logic             expired;
  logic [CNT_W-1:0] remaining;
  logic             one_hz_enable;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: interval table, whether timing is active, the loaded
  // interval, edges since the load, and edges since the divider restarted.
  int m_regs [4];
  bit m_active;
  int m_n;
  int m_k;
  int m_div;

  alarm_timer #(
    .CLK_HZ(CLK_HZ),
    .CNT_W (CNT_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .run           (run),
    .interval_sel  (interval_sel),
    .prog_sync     (prog_sync),
    .time_param_sel(time_param_sel),
    .time_value    (time_value),
    .expired       (expired),
    .remaining     (remaining),
    .one_hz_enable (one_hz_enable)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_rem();
    int r;
    if (!m_active) return 0;
    r = m_n - (m_k / int'(CLK_HZ));
    return (r > 0) ? r : 0;
  endfunction

  task automatic model_reset();
    m_regs[0] = 6;
    m_regs[1] = 8;
    m_regs[2] = 15;
    m_regs[3] = 10;
    m_active  = 1'b0;
    m_n       = 0;
    m_k       = 0;
    m_div     = 0;
  endtask

  // One clock: apply inputs, advance the model on the edge, compare just after.
  task automatic step(input bit run_v, input int sel_v, input bit prog_v,
                      input int psel_v, input int pval_v);
    int rem;
    run            = run_v;
    interval_sel   = 2'(sel_v);
    prog_sync      = prog_v;
    time_param_sel = 2'(psel_v);
    time_value     = CNT_W'(pval_v);
    @(posedge clock);
    if (!run_v) begin
      m_active = 1'b0;
      m_div++;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_n      = m_regs[sel_v];
      m_k      = 0;
      m_div    = 0;
    end else begin
      m_k++;
      m_div++;
    end
    if (prog_v) m_regs[psel_v] = pval_v;
    #1;
    rem = model_rem();
    check("remaining", int'(remaining), rem);
    check("expired", int'(expired), int'(m_active && rem == 0));
    check("one_hz_enable", int'(one_hz_enable), int'((m_div % int'(CLK_HZ)) == int'(CLK_HZ) - 1));
  endtask

  task automatic idle_step();
    step(1'b0, 0, 1'b0, 0, 0);
  endtask

  // Keep run high until expired shows up; returns edges counted after the load.
  task automatic wait_expired(input int sel_v, output int edges);
    edges = 0;
    while (!expired && edges < 200) begin
      step(1'b1, sel_v, 1'b0, 0, 0);
      edges++;
    end
  endtask

  task automatic wait_remaining(input int sel_v, input int target);
    int guard = 0;
    while (int'(remaining) != target && guard < 200) begin
      step(1'b1, sel_v, 1'b0, 0, 0);
      guard++;
    end
    check("wait_remaining_bound", int'(guard < 200), 1);
  endtask

  // Asynchronous reset between edges, held across one edge.
  task automatic apply_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_expired", int'(expired), 0);
    check("rst_remaining", int'(remaining), 0);
    check("rst_one_hz", int'(one_hz_enable), 0);
    run       = 1'b0;
    prog_sync = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int edges;
    int last_tick;
    int n_ticks;
    bit r;
    int sel;

    model_reset();
    #2;
    apply_reset();

    // Default arm delay.
    step(1'b1, 0, 1'b0, 0, 0);
    check("arm_load_rem", int'(remaining), 6);
    wait_expired(0, edges);
    check("arm_expiry_edges", edges, 24);

    // Abort at remaining 3 and restart from scratch.
    idle_step();
    step(1'b1, 0, 1'b0, 0, 0);
    wait_remaining(0, 3);
    idle_step();
    check("abort_expired", int'(expired), 0);
    check("abort_remaining", int'(remaining), 0);
    step(1'b1, 0, 1'b0, 0, 0);
    check("restart_rem", int'(remaining), 6);
    wait_expired(0, edges);
    check("restart_expiry_edges", edges, 24);
    idle_step();

    // Programming DRIVER_DELAY to 2, then to 0.
    step(1'b0, 0, 1'b1, 1, 2);
    step(1'b1, 1, 1'b0, 0, 0);
    check("drv2_rem", int'(remaining), 2);
    wait_expired(1, edges);
    check("drv2_expiry_edges", edges, 8);
    idle_step();
    step(1'b0, 0, 1'b1, 1, 0);
    step(1'b1, 1, 1'b0, 0, 0);
    check("drv0_expired_at_load", int'(expired), 1);
    idle_step();

    // Write to the selected register on the load edge uses the old value.
    step(1'b1, 2, 1'b1, 2, 3);
    check("concur_old_value", int'(remaining), 15);
    idle_step();
    step(1'b1, 2, 1'b0, 0, 0);
    check("concur_new_value", int'(remaining), 3);
    idle_step();

    // Reset mid-count restores the defaults.
    step(1'b0, 0, 1'b1, 3, 5);
    step(1'b1, 3, 1'b0, 0, 0);
    check("alarm5_rem", int'(remaining), 5);
    wait_remaining(3, 4);
    apply_reset();
    step(1'b1, 3, 1'b0, 0, 0);
    check("alarm_default_rem", int'(remaining), 10);
    idle_step();

    // Tick cadence in IDLE.
    last_tick = -1;
    n_ticks   = 0;
    for (int i = 0; i < 40; i++) begin
      idle_step();
      check("idle_expired", int'(expired), 0);
      if (one_hz_enable) begin
        if (last_tick >= 0) check("tick_spacing", i - last_tick, 4);
        last_tick = i;
        n_ticks++;
      end
    end
    check("tick_count", n_ticks, 10);

    // Randomized traffic against the model.
    r = 1'b0;
    sel = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15) == 0) r = ~r;
      if ($urandom_range(3) == 0) sel = int'($urandom_range(3));
      if ($urandom_range(7) == 0)
        step(r, sel, 1'b1, int'($urandom_range(3)), int'($urandom_range(4)));
      else
        step(r, sel, 1'b0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_timer.md
# alarm_timer

Interval timer that sits directly downstream of the arming state machine. It consumes that machine's `start_count` level and times the arm delay, driver-door, passenger-door and siren intervals. It holds four user-programmable interval registers and counts whole seconds using an internal one-second tick divider. It signals `expired` back to the alarm control logic.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: clock cycles per second. Minimum 2.
- `CNT_W`, 4: width of the interval values and the seconds counter.

Ports:
- `clock`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high.
- `run`, in, 1: level; high means timing is requested. Driven by the arm block's `start_count` or by the control FSM.
- `interval_sel`, in, 2: selects the interval. 0 = ARM_DELAY, 1 = DRIVER_DELAY, 2 = PASSENGER_DELAY, 3 = ALARM_ON. Sampled only at load.
- `prog_sync`, in, 1: single-cycle write strobe for an interval register.
- `time_param_sel`, in, 2: register addressed by `prog_sync`. Same encoding as `interval_sel`.
- `time_value`, in, CNT_W: value written by `prog_sync`.
- `expired`, out, 1: level. High while active and the remaining count is 0.
- `remaining`, out, CNT_W: seconds left in the current interval.
- `one_hz_enable`, out, 1: one-cycle pulse at each second boundary, for the status LED blink.

## Operation
- Interval registers: four registers of CNT_W bits.
  - Reset defaults: ARM_DELAY = 6, DRIVER_DELAY = 8, PASSENGER_DELAY = 15, ALARM_ON = 10.
  - A `prog_sync` high at a clock edge writes `time_value` to the register addressed by `time_param_sel`.
  - A value of 0 is legal.
- States: IDLE and COUNTING. Internal flag `active` is registered.
- IDLE to COUNTING (load):
  - Occurs at a clock edge where `run` = 1 and `active` = 0.
  - `count` is loaded with the register selected by `interval_sel`.
  - The divider is cleared.
  - `active` is set to 1.
- COUNTING:
  - On each tick edge where `count` > 0, `count` decrements by 1.
  - When `count` is 0 it holds at 0. There is no wrap and no underflow.
- COUNTING to IDLE:
  - Occurs at any edge where `run` = 0.
  - `active` is cleared to 0 and `count` is cleared to 0.
  - A later rise of `run` reloads the count from scratch; the timer never resumes a partial count.
- Outputs:
  - `expired` = `active` AND (`count` == 0), decoded combinationally from registers.
  - `remaining` = `count`.
- Divider:
  - Counts 0 to CLK_HZ−1 and wraps.
  - The tick is high in the cycle where the divider equals CLK_HZ−1.
  - The divider free-runs in both states and is cleared to 0 on a load edge.
  - `one_hz_enable` = tick.
- Simultaneous events:
  - A load and a `prog_sync` to the selected register at the same edge: the load uses the old value, and the new value applies from the next load.
  - A `prog_sync` during COUNTING never alters `count`.
  - `interval_sel` changes while COUNTING are ignored.
  - A tick at the load edge has no effect, because load has priority over decrement.
- Reset, asynchronous and at any time, including mid-count:
  - `active` = 0, `count` = 0, divider = 0.
  - Interval registers return to their defaults.
  - Outputs after reset: `expired` = 0, `remaining` = 0, `one_hz_enable` = 0.

## Timing
- Load latency: `run` is sampled high at edge E. From E onward `remaining` = N and `active` = 1.
- Expiry: `expired` rises exactly N·CLK_HZ cycles after E.
  - For N = 0, `expired` is high from E, in the first cycle after the edge.
- Deassert: `run` is sampled low at edge F. `expired` and `remaining` are 0 from F.
- Ticks after a load: the first tick follows CLK_HZ−1 cycles after E, and ticks then repeat every CLK_HZ cycles.
- Register writes: a `prog_sync` at edge P takes effect for any load at an edge after P.

## Structure
- Package `alarm_pkg` holds:
  - the `interval_sel` / `time_param_sel` encodings (ARM_DELAY, DRIVER_DELAY, PASSENGER_DELAY, ALARM_ON);
  - the four default interval constants;
  - the IDLE/COUNTING state encoding.
- Sub-module `one_hz_div`:
  - Parameter: CLK_HZ.
  - Ports: `clock`, `reset`, `clear`, `tick`.
  - It is instantiated once. The interval registers and the countdown stay in the top level.

## Test plan
All scenarios use CLK_HZ = 4.
- Default arm delay: reset, then `interval_sel` = 0 and `run` = 1 held → `remaining` = 6 after the load edge, and `expired` rises exactly 24 cycles after the load edge.
- Abort and restart: `run` drops at `remaining` = 3 → `expired` and `remaining` are 0 the next cycle. `run` rises again → `remaining` reloads to 6, and `expired` rises 24 cycles after the new load.
- Programming: write DRIVER_DELAY = 2, then run with `interval_sel` = 1 → `expired` after 8 cycles. Write 0, then run → `expired` in the first cycle after the load edge.
- Concurrency: `prog_sync` PASSENGER_DELAY = 3 at the same edge as a load of `interval_sel` = 2 → `remaining` = 15. A second run after `run` drops → `remaining` = 3.
- Reset mid-count: assert `reset` at `remaining` = 4 with ALARM_ON programmed to 5 → all outputs 0 immediately. A subsequent load of `interval_sel` = 3 gives `remaining` = 10.
- Tick cadence: over 40 cycles in IDLE, `one_hz_enable` pulses every 4 cycles, each pulse exactly one cycle wide, and `expired` stays 0 throughout.
